// File: rtl/fifo_fwft_flagged.sv
// First-word-fall-through FIFO for any DEPTH >= 2, with occupancy count, programmable
// almost-full/almost-empty flags and sticky overflow/underflow error flags.
module fifo_fwft_flagged #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [PW-1:0]    head_inc, tail_inc;
  logic             wr_acc, rd_acc;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] dout_nxt;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  assign wr_acc   = wr_en & ~full;
  assign rd_acc   = rd_en & ~empty;
  assign head_inc = ptr_inc(head);
  assign tail_inc = ptr_inc(tail);

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // dout mirrors the head word; it bypasses RAM whenever the incoming word becomes head.
  always_comb begin
    dout_nxt = dout;
    if (wr_acc && (empty || (rd_acc && count == CW'(1))))
      dout_nxt = din;
    else if (rd_acc && count >= CW'(2))
      dout_nxt = mem[head_inc];
  end

  always_ff @(posedge clk) begin
    if (!srst && wr_acc)
      mem[tail] <= din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) tail <= tail_inc;
      if (rd_acc) head <= head_inc;
      count <= count_nxt;
      dout  <= dout_nxt;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

endmodule
